// File: rtl/sat_counter_bht.sv
// Branch history table of saturating counters with registered lookup, write-first bypass
// and a saturating mispredict counter. Define SAT_BHT_GSHARE_EN to XOR a global history into the index.
module sat_counter_bht #(
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned PC_SHIFT   = 2,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lookup_valid,
  input  logic [PC_BITS-1:0]    lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [CTR_BITS-1:0]   pred_ctr,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_pred,
  output logic [STAT_BITS-1:0]  mispredict_cnt
);

  localparam int unsigned          DEPTH    = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CTR_BITS-1:0]   ctr_q [DEPTH];
  logic [INDEX_BITS-1:0] pc_idx_c;
  logic [INDEX_BITS-1:0] lk_idx_c;
  logic [CTR_BITS-1:0]   upd_ctr_c;
  logic [CTR_BITS-1:0]   lk_ctr_c;
  logic                  unused_pc;

  assign pc_idx_c  = lookup_pc[PC_SHIFT +: INDEX_BITS];
  assign unused_pc = ^lookup_pc;

`ifdef SAT_BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;

  assign lk_idx_c = pc_idx_c ^ ghr_q;

  // History shifts after the update edge, so a same-cycle lookup hashes with the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
    end
  end
`else
  assign lk_idx_c = pc_idx_c;
`endif

  // Saturating +/-1 step of the entry being updated.
  always_comb begin
    upd_ctr_c = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != CTR_MAX) upd_ctr_c = ctr_q[upd_idx] + CTR_BITS'(1);
    end else begin
      if (ctr_q[upd_idx] != '0) upd_ctr_c = ctr_q[upd_idx] - CTR_BITS'(1);
    end
  end

  // Write-first: a lookup hitting the entry being updated sees the new value.
  always_comb begin
    lk_ctr_c = ctr_q[lk_idx_c];
    if (upd_valid && (upd_idx == lk_idx_c)) lk_ctr_c = upd_ctr_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= upd_ctr_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= '0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= lk_ctr_c[CTR_BITS-1];
        pred_ctr   <= lk_ctr_c;
        pred_idx   <= lk_idx_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && (upd_taken != upd_pred) && (mispredict_cnt != STAT_MAX)) begin
      mispredict_cnt <= mispredict_cnt + STAT_BITS'(1);
    end
  end

endmodule
